// File: rtl/systolic_operand_feeder_if.sv
// Operand feeder bus: operand storage write port, start/status handshake and
// the six unskewed operand lanes driven into the 3x3 systolic array.
//   wr_en/wr_addr/wr_data : element write (0..8 = A[r][c], 9..17 = B[r][c])
//   wr_ignored            : pulse, the previous write was dropped
//   start/busy/done       : operation request and status
//   arr_clr               : array accumulator clear
//   a1..a3 / b1..b3       : row operands of A / column operands of B
interface systolic_operand_feeder_if #(
  parameter int unsigned DW = 2
);
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ignored;
  logic          start;
  logic          busy;
  logic          done;
  logic          arr_clr;
  logic [DW-1:0] a1;
  logic [DW-1:0] a2;
  logic [DW-1:0] a3;
  logic [DW-1:0] b1;
  logic [DW-1:0] b2;
  logic [DW-1:0] b3;

  // Feeder side
  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output wr_ignored, busy, done, arr_clr, a1, a2, a3, b1, b2, b3
  );

  // Controller / environment side
  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  wr_ignored, busy, done, arr_clr, a1, a2, a3, b1, b2, b3
  );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Upstream feeder for the 3x3 systolic multiplier. Stores A and B (3x3 each,
// DW-bit elements); on start it clears the array accumulators for one cycle,
// streams column k of A and row k of B for k=0..2, drives zeros for DRAIN
// cycles and then pulses done. All outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : feeder side of systolic_operand_feeder_if
module systolic_operand_feeder #(
  parameter int unsigned DW    = 2,
  parameter int unsigned DRAIN = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  systolic_operand_feeder_if.slave      bus
);

  localparam int unsigned NELEM = 18;
  localparam int unsigned SMAX  = (DRAIN > 3) ? DRAIN : 3;
  localparam int unsigned CW    = $clog2(SMAX + 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [DW-1:0] mem_q [NELEM];
  logic [DW-1:0] mem_d [NELEM];
  logic [DW-1:0] a_q [3];
  logic [DW-1:0] a_d [3];
  logic [DW-1:0] b_q [3];
  logic [DW-1:0] b_d [3];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clr_q, clr_d;
  logic          ign_q, ign_d;
  logic          wr_ok_c;

  // Writes are only taken while idle and within the 18-element map
  assign wr_ok_c = bus.wr_en && (bus.wr_addr <= 5'd17) && !busy_q;

  // Operand storage update
  always_comb begin
    mem_d = mem_q;
    if (wr_ok_c) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Next state, step counter and status outputs
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (bus.start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        step_d  = '0;
      end
      S_STREAM: begin
        if (step_q == STREAM_LAST) begin
          state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase

    // Outputs are registered from the state being entered
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
    ign_d  = bus.wr_en && !wr_ok_c;
  end

  // Unskewed operand lanes: a_i = A[i][k], b_j = B[k][j]
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a_d[i] = '0;
      b_d[i] = '0;
    end
    if (state_d == S_STREAM) begin
      for (int i = 0; i < 3; i++) begin
        a_d[i] = mem_q[5'(3 * i) + 5'(step_d)];
        b_d[i] = mem_q[5'(9) + 5'(3) * 5'(step_d) + 5'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      mem_q   <= '{default: '0};
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mem_q   <= mem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      ign_q   <= ign_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.arr_clr    = clr_q;
  assign bus.wr_ignored = ign_q;
  assign bus.a1         = a_q[0];
  assign bus.a2         = a_q[1];
  assign bus.a3         = a_q[2];
  assign bus.b1         = b_q[0];
  assign bus.b2         = b_q[1];
  assign bus.b3         = b_q[2];

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder. A bench-side copy of the
// operand storage produces the expected per-cycle output record, which is
// queued when an operation is launched and popped as each cycle is observed.
module tb_systolic_operand_feeder;

  localparam int unsigned DW    = 2;
  localparam int unsigned DRAIN = 5;
  localparam int          OPLEN = 1 + 3 + DRAIN + 1;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            clr;
    logic            ign;
    logic [3*DW-1:0] a;
    logic [3*DW-1:0] b;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_operand_feeder_if #(.DW(DW)) bus ();

  systolic_operand_feeder #(.DW(DW), .DRAIN(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            checks   = 0;
  int            failures = 0;
  obs_t          sb[$];
  logic [DW-1:0] mem_m [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.busy = bus.busy;
    s.done = bus.done;
    s.clr  = bus.arr_clr;
    s.ign  = bus.wr_ignored;
    s.a    = {bus.a1, bus.a2, bus.a3};
    s.b    = {bus.b1, bus.b2, bus.b3};
    return s;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_next(input string tag);
    obs_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard_empty expected=record", tag);
    end else begin
      e = sb.pop_front();
      check(tag, sample(), e);
    end
  endtask

  // Queue the expected records for one operation from the model storage
  task automatic push_op(input int ign_at);
    obs_t r;
    int   k;
    for (int i = 0; i < OPLEN; i++) begin
      r      = '0;
      r.busy = 1'b1;
      if (i == 0) begin
        r.clr = 1'b1;
      end else if (i <= 3) begin
        k   = i - 1;
        r.a = {mem_m[k], mem_m[3+k], mem_m[6+k]};
        r.b = {mem_m[9+3*k], mem_m[10+3*k], mem_m[11+3*k]};
      end else if (i == OPLEN - 1) begin
        r.done = 1'b1;
      end
      if (ign_at >= 0 && i == ign_at + 1) r.ign = 1'b1;
      sb.push_back(r);
    end
  endtask

  task automatic push_idle();
    obs_t r;
    r = '0;
    sb.push_back(r);
  endtask

  // Idle-time write; expects wr_ignored only for out-of-map addresses
  task automatic write(input logic [4:0] addr, input logic [DW-1:0] data);
    obs_t e;
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    e = '0;
    e.ign = (addr > 5'd17);
    if (addr <= 5'd17) mem_m[addr] = data;
    check("idle_write", sample(), e);
  endtask

  // One operation. wr_at: cycle to attempt a write while busy (-1 none).
  // abort_at: cycle after which reset is held for 2 cycles (-1 none).
  // same_wr: write A[0][0]=same_val on the start edge.
  task automatic run_op(input string tag, input int wr_at, input int abort_at,
                        input bit same_wr, input logic [DW-1:0] same_val);
    obs_t z;
    z = '0;
    if (same_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd0;
      bus.wr_data = same_val;
      mem_m[0]    = same_val;
    end
    push_op(wr_at);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int i = 0; i < OPLEN; i++) begin
      check_next(tag);
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        check({tag, "_reset1"}, sample(), z);
        tick();
        check({tag, "_reset2"}, sample(), z);
        reset = 1'b0;
        sb.delete();
        for (int j = 0; j < 18; j++) mem_m[j] = '0;
        return;
      end
      if (i == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = ~mem_m[0];
      end
      tick();
      bus.wr_en = 1'b0;
    end
    push_idle();
    check_next({tag, "_idle"});
  endtask

  initial begin
    obs_t z;
    z           = '0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    for (int j = 0; j < 18; j++) mem_m[j] = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_state", sample(), z);

    // A = [[1,2,3],[0,1,2],[3,3,1]], B = identity
    write(5'd0, 2'd1); write(5'd1, 2'd2); write(5'd2, 2'd3);
    write(5'd3, 2'd0); write(5'd4, 2'd1); write(5'd5, 2'd2);
    write(5'd6, 2'd3); write(5'd7, 2'd3); write(5'd8, 2'd1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        write(5'(9 + 3 * r + c), (r == c) ? 2'd1 : 2'd0);
    run_op("load_stream", -1, -1, 1'b0, '0);

    // Out-of-map writes are dropped
    write(5'd18, 2'd3);
    write(5'd31, 2'd2);
    run_op("after_bad_addr", -1, -1, 1'b0, '0);

    // Write during busy is dropped and leaves storage intact
    run_op("busy_write", 3, -1, 1'b0, '0);
    run_op("after_busy_write", -1, -1, 1'b0, '0);

    // Write and start on the same edge
    run_op("same_edge", -1, -1, 1'b1, 2'd2);

    // Held start: two back-to-back operations with one idle cycle between
    push_op(-1);
    push_idle();
    push_op(-1);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 2 * OPLEN + 1; i++) begin
      check_next("held_start");
      if (i == 2 * OPLEN) bus.start = 1'b0;
      tick();
    end
    push_idle();
    check_next("held_start_end");

    // All elements at full scale
    for (int j = 0; j < 18; j++) write(5'(j), 2'd3);
    run_op("all_threes", -1, -1, 1'b0, '0);

    // Reset mid-STREAM, then storage must read back as zeros
    run_op("mid_reset", -1, 2, 1'b0, '0);
    run_op("after_reset", -1, -1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Upstream stage of the 3x3 systolic multiplier. Holds operand matrices A and B, each 3x3 with DW-bit elements, in local storage.
- On a start request it clears the array's PE accumulators, then streams one column of A and one row of B per cycle onto a1..a3 / b1..b3. The array performs its own diagonal skew internally, so the feeder drives unskewed values.
- After streaming, it drives zeros for DRAIN cycles so the last products reach the far PE, then pulses done.

Parameters:
- DW, 2, element width; must match the array's a/b width.
- DRAIN, 5, zero-drive cycles after streaming. The minimum for a correct result is 5, covering 4 skew registers to the far corner plus 1 accumulate.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for operand storage.
- wr_addr  in  5  element address: 0..8 = A[r][c] at 3r+c; 9..17 = B[r][c] at 9+3r+c.
- wr_data  in  DW  element value.
- wr_ignored  out  1  one-cycle pulse: the write was dropped (address above 17, or busy high).
- start  in  1  level request to begin a multiply; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the done cycle, inclusive.
- done  out  1  one-cycle pulse on the final cycle of an operation.
- arr_clr  out  1  accumulator clear for the array; the integrator ORs it into the array reset.
- a1, a2, a3  out  DW each  row-i operand for the array: A[i-1][k] during stream step k.
- b1, b2, b3  out  DW each  column-j operand for the array: B[k][j-1] during stream step k.

Behaviour:
- Reset, at any time including mid-operation:
  - state = IDLE; all 18 storage elements = 0.
  - a1..a3, b1..b3 = 0; arr_clr, busy, done, wr_ignored = 0; step counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- Writes:
  - Accepted when wr_en=1, wr_addr<=17 and busy=0. The element updates at that edge.
  - Otherwise, when wr_en=1, storage is unchanged and wr_ignored=1 in the next cycle.
- State machine:
  - IDLE: all outputs 0. start=1 -> CLEAR. start while busy has no effect and is not queued.
  - CLEAR: exactly 1 cycle; arr_clr=1, operands 0, busy=1 -> STREAM.
  - STREAM: 3 cycles, k=0,1,2; operands as defined in Ports; arr_clr=0 -> DRAIN.
  - DRAIN: DRAIN cycles; all operands 0 -> DONE.
  - DONE: 1 cycle; done=1, busy=1, operands 0 -> IDLE.
- Timing:
  - The start edge is in IDLE; the CLEAR cycle follows it.
  - Start acceptance to the done cycle = 1 + 3 + DRAIN + 1 cycles (10 at default).
  - start held high re-triggers from IDLE on the edge after DONE. There is 1 IDLE cycle between operations.
- A write and start at the same IDLE edge: the write is accepted (busy still 0) and the new value is used in STREAM.
- Storage is never modified by an operation. Back-to-back starts reuse the same operands.
- Arithmetic: none. Values pass through unchanged; the DW-bit width is preserved.
- DRAIN values below 5 are legal but give an incomplete result in the far PEs. This is not checked in hardware.

Test Plan:
- Reset: assert reset 2 cycles mid-STREAM -> next cycle all outputs 0 and busy=0; a subsequent start streams zeros, because storage was cleared.
- Load and stream:
  - Stimulus: write A=[[1,2,3],[0,1,2],[3,3,1]], B=identity, then pulse start.
  - Cycle 1 (CLEAR): arr_clr=1.
  - Cycles 2-4: (a1,a2,a3)=(1,0,3),(2,1,3),(3,2,1); (b1,b2,b3)=(1,0,0),(0,1,0),(0,0,1).
  - Then 5 zero cycles and done in cycle 10.
- Integrated with the array, A=B=all 3s -> every result 27. The array's 5-bit output holds 27, so there is no overflow.
- Writes:
  - wr_addr=18 -> wr_ignored pulses; storage unchanged.
  - A write during busy -> wr_ignored pulses; a later readout of the stream is unchanged.
- Same-edge write and start: write A[0][0]=2 together with start -> a1=2 in the first STREAM cycle.
- Held start: start high for 25 cycles -> done pulses 11 cycles apart. busy drops for exactly 1 cycle between operations; arr_clr pulses at each CLEAR.
